// File: rtl/vend_unit.sv
// Vending-machine core: coin accumulation, price check, dispense and change/refund sequencing.
// Optional build macro VEND_CHANGE_EN: when defined, a purchase returns credit minus price as change.
module vend_unit #(
    parameter int W       = 8,
    parameter int N_ITEMS = 4,
    localparam int SW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 coin_valid_i,
    input  logic [W-1:0]         coin_value_i,
    input  logic                 sel_valid_i,
    input  logic [SW-1:0]        sel_i,
    input  logic                 cancel_i,
    input  logic [N_ITEMS*W-1:0] price_i,
    output logic [W-1:0]         credit_o,
    output logic                 busy_o,
    output logic                 coin_reject_o,
    output logic                 short_o,
    output logic                 dispense_o,
    output logic [SW-1:0]        item_o,
    output logic                 change_valid_o,
    output logic [W-1:0]         change_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_RETURN   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    credit_r;
    logic [W-1:0]    credit_s;
    logic [W-1:0]    change_r;
    logic [W-1:0]    change_s;
    logic [W:0]      sum_s;
    logic [W-1:0]    price_s;
    logic            sel_ok_s;
    logic            busy_s;
    logic            coin_reject_s;
    logic            short_s;
    logic            dispense_s;
    logic [SW-1:0]   item_s;
    logic            change_valid_s;
    logic [W-1:0]    change_out_s;

    assign credit_o = credit_r;

    // Price lookup for the selected item; out-of-range indices leave sel_ok_s low.
    always_comb begin
        price_s  = '0;
        sel_ok_s = 1'b0;
        for (int k = 0; k < N_ITEMS; k++) begin
            price_s  = (sel_i == SW'(k)) ? price_i[k*W +: W] : price_s;
            sel_ok_s = sel_ok_s | (sel_i == SW'(k));
        end
    end

    // One extra bit catches credit overflow on a coin insert.
    always_comb begin
        sum_s = {1'b0, credit_r} + {1'b0, coin_value_i};
    end

    // Next-state and next-output logic; pulse outputs are registered from these.
    always_comb begin
        state_s        = state_r;
        credit_s       = credit_r;
        change_s       = change_r;
        coin_reject_s  = 1'b0;
        short_s        = 1'b0;
        dispense_s     = 1'b0;
        item_s         = '0;
        change_valid_s = 1'b0;
        change_out_s   = '0;
        case (state_r)
            S_IDLE, S_COLLECT: begin
                if (cancel_i && (state_r == S_COLLECT)) begin
                    state_s        = S_RETURN;
                    change_valid_s = 1'b1;
                    change_out_s   = credit_r;
                    coin_reject_s  = coin_valid_i;
                end else if (sel_valid_i) begin
                    // Selection is judged on pre-coin credit; a concurrent coin is bounced.
                    coin_reject_s = coin_valid_i;
                    if (!sel_ok_s || (credit_r < price_s)) begin
                        short_s = 1'b1;
                    end else begin
                        state_s    = S_DISPENSE;
                        dispense_s = 1'b1;
                        item_s     = sel_i;
`ifdef VEND_CHANGE_EN
                        change_s   = credit_r - price_s;
`else
                        change_s   = '0;
`endif
                    end
                end else if (coin_valid_i) begin
                    if (sum_s[W]) begin
                        coin_reject_s = 1'b1;
                    end else if (coin_value_i != '0) begin
                        credit_s = sum_s[W-1:0];
                        state_s  = S_COLLECT;
                    end else begin
                        credit_s = credit_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_DISPENSE: begin
                state_s        = S_RETURN;
                coin_reject_s  = coin_valid_i;
                change_valid_s = (change_r != '0);
                change_out_s   = change_r;
            end
            S_RETURN: begin
                state_s       = S_IDLE;
                credit_s      = '0;
                change_s      = '0;
                coin_reject_s = coin_valid_i;
            end
            default: begin
                state_s  = S_IDLE;
                credit_s = '0;
                change_s = '0;
            end
        endcase
        busy_s = (state_s == S_DISPENSE) || (state_s == S_RETURN);
    end

    // State, credit and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= S_IDLE;
            credit_r       <= '0;
            change_r       <= '0;
            busy_o         <= 1'b0;
            coin_reject_o  <= 1'b0;
            short_o        <= 1'b0;
            dispense_o     <= 1'b0;
            item_o         <= '0;
            change_valid_o <= 1'b0;
            change_o       <= '0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            change_r       <= change_s;
            busy_o         <= busy_s;
            coin_reject_o  <= coin_reject_s;
            short_o        <= short_s;
            dispense_o     <= dispense_s;
            item_o         <= item_s;
            change_valid_o <= change_valid_s;
            change_o       <= change_out_s;
        end
    end

endmodule

// File: tb/tb_vend_unit.sv
// Randomised and directed bench for vend_unit against a transaction-level vending model.
module tb_vend_unit;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 2;
`ifdef VEND_CHANGE_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            coin_valid;
    logic [W-1:0]    coin_value;
    logic            sel_valid;
    logic [SW-1:0]   sel;
    logic            cancel;
    logic [N*W-1:0]  price;
    logic [W-1:0]    credit;
    logic            busy, coin_reject, short_p, dispense;
    logic [SW-1:0]   item;
    logic            change_valid;
    logic [W-1:0]    change;

    always #5 clk = ~clk;

    vend_unit #(.W(W), .N_ITEMS(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .coin_valid_i(coin_valid), .coin_value_i(coin_value),
        .sel_valid_i(sel_valid), .sel_i(sel), .cancel_i(cancel),
        .price_i(price),
        .credit_o(credit), .busy_o(busy), .coin_reject_o(coin_reject),
        .short_o(short_p), .dispense_o(dispense), .item_o(item),
        .change_valid_o(change_valid), .change_o(change)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int prices [N] = '{30, 50, 50};

    // Model: credit held, phase counter after a purchase/refund (0 ready, 1 dispensing, 2 returning).
    int m_credit, m_phase, m_pend;
    int e_rej, e_short, e_disp, e_item, e_cv, e_chg, e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_phase = 0; m_pend = 0;
        e_rej = 0; e_short = 0; e_disp = 0; e_item = 0; e_cv = 0; e_chg = 0; e_busy = 0;
    endtask

    task automatic model_step();
        e_rej = 0; e_short = 0; e_disp = 0; e_item = 0; e_cv = 0; e_chg = 0;
        if (m_phase == 1) begin
            m_phase = 2;
            e_rej   = int'(coin_valid);
            if (CHG && m_pend > 0) begin
                e_cv  = 1;
                e_chg = m_pend;
            end
        end else if (m_phase == 2) begin
            m_phase  = 0;
            m_credit = 0;
            e_rej    = int'(coin_valid);
        end else if (cancel && m_credit > 0) begin
            e_rej   = int'(coin_valid);
            m_phase = 2;
            e_cv    = 1;
            e_chg   = m_credit;
        end else if (sel_valid) begin
            e_rej = int'(coin_valid);
            if (int'(sel) >= N || m_credit < prices[sel]) begin
                e_short = 1;
            end else begin
                m_phase = 1;
                e_disp  = 1;
                e_item  = int'(sel);
                m_pend  = m_credit - prices[sel];
            end
        end else if (coin_valid) begin
            if (m_credit + int'(coin_value) > 255) e_rej = 1;
            else m_credit = m_credit + int'(coin_value);
        end
        e_busy = (m_phase != 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("credit", 32'(credit), 32'(m_credit));
        check("busy", 32'(busy), 32'(e_busy));
        check("coin_reject", 32'(coin_reject), 32'(e_rej));
        check("short", 32'(short_p), 32'(e_short));
        check("dispense", 32'(dispense), 32'(e_disp));
        check("item", 32'(item), 32'(e_item));
        check("change_valid", 32'(change_valid), 32'(e_cv));
        check("change", 32'(change), 32'(e_chg));
    endtask

    task automatic cycle(input bit cv, input int val, input bit sv, input int s, input bit cn);
        coin_valid = cv; coin_value = W'(val); sel_valid = sv; sel = SW'(s); cancel = cn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_credit_lit", 32'(credit), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        price      = {8'd50, 8'd50, 8'd30};
        coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;
        rst_ni     = 1'b0;
        @(negedge clk);
        do_reset();

        // Coins 25,25,10 then buy item 2 at 50.
        cycle(1'b1, 25, 1'b0, 0, 1'b0); check("a_c25", 32'(credit), 32'd25);
        cycle(1'b1, 25, 1'b0, 0, 1'b0); check("a_c50", 32'(credit), 32'd50);
        cycle(1'b1, 10, 1'b0, 0, 1'b0); check("a_c60", 32'(credit), 32'd60);
        cycle(1'b0, 0, 1'b1, 2, 1'b0);
        check("a_disp", 32'(dispense), 32'd1);
        check("a_item", 32'(item), 32'd2);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check("a_cv", 32'(change_valid), CHG ? 32'd1 : 32'd0);
        check("a_chg", 32'(change), CHG ? 32'd10 : 32'd0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0); check("a_clr", 32'(credit), 32'd0);

        // Short selections, then cancel refund.
        cycle(1'b1, 20, 1'b0, 0, 1'b0);
        cycle(1'b1, 20, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1, 1'b0);
        check("b_short", 32'(short_p), 32'd1);
        check("b_credit", 32'(credit), 32'd40);
        cycle(1'b0, 0, 1'b1, 3, 1'b0); check("b_short_oor", 32'(short_p), 32'd1);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check("b_refund", 32'(change), 32'd40);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Overflow boundary.
        cycle(1'b1, 250, 1'b0, 0, 1'b0);
        cycle(1'b1, 10, 1'b0, 0, 1'b0);
        check("c_rej", 32'(coin_reject), 32'd1);
        check("c_250", 32'(credit), 32'd250);
        cycle(1'b1, 5, 1'b0, 0, 1'b0); check("c_255", 32'(credit), 32'd255);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Cancel beats selection and coin.
        cycle(1'b1, 30, 1'b0, 0, 1'b0);
        cycle(1'b1, 10, 1'b1, 2, 1'b1);
        check("d_rej", 32'(coin_reject), 32'd1);
        check("d_chg", 32'(change), 32'd30);
        check("d_nodisp", 32'(dispense), 32'd0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Exact-price buy with coin and selection arriving while dispensing.
        cycle(1'b1, 50, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1, 1'b0);
        cycle(1'b1, 10, 1'b1, 0, 1'b0);
        check("e_rej", 32'(coin_reject), 32'd1);
        check("e_nochg", 32'(change_valid), 32'd0);
        check("e_noshort", 32'(short_p), 32'd0);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);

        // Reset in the middle of collecting.
        cycle(1'b1, 35, 1'b0, 0, 1'b0); check("f_35", 32'(credit), 32'd35);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit cv, sv, cn;
            int val;
            cv  = ($urandom_range(0, 99) < 40);
            val = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60));
            sv  = ($urandom_range(0, 99) < 20);
            cn  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle(cv, val, sv, int'($urandom_range(0, 3)), cn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_unit.md
# vend_unit

Parametrised vending-machine core that merges the coin accumulator, price comparison and purchase/refund sequencing into one clocked block. It accepts coins of arbitrary value, holds a per-item price table, dispenses on a valid selection when credit covers the price, and returns change or a full refund. It sits between the coin acceptor/keypad front-end and the dispenser/coin-return actuators.

## Interface
Parameters:
- `W`, 8, width of coin values, prices, credit and change.
- `N_ITEMS`, 4, number of selectable items; `SW = $clog2(N_ITEMS)`, minimum 1.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `coin_valid_i`  in  1  one-cycle strobe, coin present.
- `coin_value_i`  in  W  value of the strobed coin.
- `sel_valid_i`  in  1  one-cycle strobe, item selected.
- `sel_i`  in  SW  selected item index.
- `cancel_i`  in  1  one-cycle strobe, refund request.
- `price_i`  in  N_ITEMS*W  price table, item k at bits [k*W +: W]; treated as static.
- `credit_o`  out  W  current credit (registered).
- `busy_o`  out  1  high in DISPENSE and RETURN.
- `coin_reject_o`  out  1  one-cycle pulse, coin not credited.
- `short_o`  out  1  one-cycle pulse, selection refused for insufficient credit.
- `dispense_o`  out  1  one-cycle pulse, release item.
- `item_o`  out  SW  item being dispensed, valid with `dispense_o`.
- `change_valid_o`  out  1  one-cycle pulse, return `change_o`.
- `change_o`  out  W  amount to return, valid with `change_valid_o`.

## Operation
- States: IDLE (credit 0), COLLECT (credit > 0), DISPENSE, RETURN.
- Coin in IDLE/COLLECT: if credit + coin_value_i fits in W bits (computed at W+1), credit += value, go/stay COLLECT; else credit unchanged, `coin_reject_o`. Zero-value coin: accepted, no effect, state unchanged.
- Coin in DISPENSE/RETURN: rejected (`coin_reject_o`).
- Selection in IDLE/COLLECT: sel_i >= N_ITEMS or credit < price → `short_o`, no state change. Credit >= price → latch sel_i and change = credit − price, go DISPENSE.
- Selection while busy: ignored, no pulse.
- Cancel in COLLECT: change = credit, go RETURN. Cancel in IDLE or while busy: ignored.
- DISPENSE (1 cycle): `dispense_o`=1, `item_o`=latched index; next RETURN.
- RETURN (1 cycle): if change > 0, `change_valid_o`=1 with `change_o`; credit cleared; next IDLE. Change 0 → no pulse.
- Same-cycle priority in IDLE/COLLECT: cancel > selection > coin. Lower-priority coin is rejected (`coin_reject_o`); lower-priority selection is dropped silently.
- Selection evaluated against credit before any same-cycle coin.

## Timing
- Reset (async assert, sync-safe deassert at next edge): state IDLE, credit_o=0, all pulse outputs 0, item_o=0, change_o=0, busy_o=0.
- Accepted coin → credit_o updated 1 cycle later; `coin_reject_o`/`short_o` asserted in the cycle after the strobe.
- Sufficient selection at cycle t → `dispense_o` at t+1, `change_valid_o` at t+2, credit_o=0 from t+3 state (IDLE at t+3).
- Cancel at t → `change_valid_o` at t+1, IDLE at t+2.
- Reset mid-DISPENSE/RETURN: pulse aborted, credit lost, IDLE.
- credit_o holds value through DISPENSE and RETURN, cleared on RETURN→IDLE.

## Configuration
- `VEND_CHANGE_EN` defined: behaviour as above, change = credit − price on purchase.
- Undefined: purchase returns no change — RETURN after DISPENSE emits no `change_valid_o`, excess credit is kept (cleared); cancel refunds still operate; `change_o` driven only on cancel.

## Test plan
- Reset: rst_ni low mid-COLLECT with credit 35 → all outputs 0, IDLE, credit_o=0 immediately.
- Coins 25,25,10 then sel 2 (price 50) → credit_o 25,50,60; `dispense_o` item_o=2; `change_valid_o` change_o=10 (0 pulses without `VEND_CHANGE_EN`); credit_o=0.
- Credit 40, sel 1 (price 50) → `short_o` one cycle, credit_o stays 40; sel_i=N_ITEMS → `short_o`.
- W=8, credit 250, coin 10 → `coin_reject_o`, credit_o 250; coin 5 → 255 accepted.
- Credit 30, cancel+sel+coin same cycle → coin rejected, `change_valid_o` change_o=30, no dispense.
- Coin and sel during DISPENSE → `coin_reject_o`, selection ignored, exact price purchase gives no change pulse.
